// File: rtl/hvsync_pkg.sv
// Shared VGA 640x480@60 timing constants, derived window bounds and the
// coordinate type used by the sync generator and its axis counters.
package hvsync_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_BOTTOM  = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOP     = 33;

  localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_MAX        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/hv_sync_generator_if.sv
// Video timing bundle: sync levels, visible-area flag and pixel coordinates.
// The generator drives it through master; pixel logic samples it through slave.
interface hv_sync_generator_if;
  import hvsync_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   display_on;
  logic   frame_end;
  coord_t hpos;
  coord_t vpos;

  modport master (output hsync, vsync, display_on, frame_end, hpos, vpos);
  modport slave  (input  hsync, vsync, display_on, frame_end, hpos, vpos);

endinterface

// File: rtl/sync_axis_counter.sv
// One timing axis: wrapping position counter plus a registered in-sync-window
// flag, computed from the next count so it lines up with the count itself.
module sync_axis_counter
  import hvsync_pkg::*;
#(
  parameter int DISPLAY = H_DISPLAY,
  parameter int FRONT   = H_FRONT,
  parameter int SYNC    = H_SYNC,
  parameter int BACK    = H_BACK
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t count,
  output logic   wrap,
  output logic   sync_win
);

  localparam coord_t MAX        = coord_t'(DISPLAY + FRONT + SYNC + BACK - 1);
  localparam coord_t SYNC_START = coord_t'(DISPLAY + FRONT);
  localparam coord_t SYNC_END   = coord_t'(DISPLAY + FRONT + SYNC - 1);

  coord_t count_nxt;

  always_comb begin
    wrap      = advance && (count == MAX);
    count_nxt = count;
    if (wrap) begin
      count_nxt = '0;
    end else if (advance) begin
      count_nxt = count + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      sync_win <= 1'b0;
    end else begin
      count    <= count_nxt;
      sync_win <= (count_nxt >= SYNC_START) && (count_nxt <= SYNC_END);
    end
  end

endmodule

// File: rtl/hv_sync_generator.sv
// Free-running VGA timing generator (horizontal and vertical axis counters).
// Define HVSYNC_POS_POLARITY_EN for active-high hsync/vsync; default is active-low.
module hv_sync_generator #(
  parameter int H_DISPLAY = hvsync_pkg::H_DISPLAY,
  parameter int H_FRONT   = hvsync_pkg::H_FRONT,
  parameter int H_SYNC    = hvsync_pkg::H_SYNC,
  parameter int H_BACK    = hvsync_pkg::H_BACK,
  parameter int V_DISPLAY = hvsync_pkg::V_DISPLAY,
  parameter int V_BOTTOM  = hvsync_pkg::V_BOTTOM,
  parameter int V_SYNC    = hvsync_pkg::V_SYNC,
  parameter int V_TOP     = hvsync_pkg::V_TOP
) (
  input  logic                 clk,
  input  logic                 reset,
  hv_sync_generator_if.master  vid
);
  import hvsync_pkg::coord_t;

  coord_t h_count;
  coord_t v_count;
  logic   h_wrap;
  logic   v_wrap;
  logic   h_win;
  logic   v_win;

  sync_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .advance  (1'b1),
    .count    (h_count),
    .wrap     (h_wrap),
    .sync_win (h_win)
  );

  // The vertical axis steps once per line, on the clock the horizontal axis wraps.
  sync_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_BOTTOM),
    .SYNC    (V_SYNC),
    .BACK    (V_TOP)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .advance  (h_wrap),
    .count    (v_count),
    .wrap     (v_wrap),
    .sync_win (v_win)
  );

`ifdef HVSYNC_POS_POLARITY_EN
  assign vid.hsync = h_win;
  assign vid.vsync = v_win;
`else
  assign vid.hsync = ~h_win;
  assign vid.vsync = ~v_win;
`endif

  assign vid.hpos       = h_count;
  assign vid.vpos       = v_count;
  assign vid.display_on = (h_count < coord_t'(H_DISPLAY)) && (v_count < coord_t'(V_DISPLAY));
  assign vid.frame_end  = v_wrap;

endmodule

// File: tb/tb_hv_sync_generator.sv
// Bench for hv_sync_generator: a full-size instance for line-level timing and a
// shrunken instance so whole frames fit in a short run.
module tb_hv_sync_generator;
  import hvsync_pkg::*;

  localparam int SHD = 16;
  localparam int SHF = 2;
  localparam int SHS = 4;
  localparam int SHB = 3;
  localparam int SVD = 12;
  localparam int SVF = 2;
  localparam int SVS = 2;
  localparam int SVB = 3;
  localparam int S_FRAME = (SHD + SHF + SHS + SHB) * (SVD + SVF + SVS + SVB);

`ifdef HVSYNC_POS_POLARITY_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fe;
  } pix_t;

  localparam pix_t RST_PIX = {10'd0, 10'd0, ~SYNC_ON, ~SYNC_ON, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_d;
  logic rst_s;
  int   t_d;
  int   t_s;
  int   n_cmp = 0;
  int   n_err = 0;

  always #20 clk = ~clk;

  // Clocks elapsed since each instance left reset.
  always @(posedge clk or posedge rst_d) begin
    if (rst_d) t_d <= 0;
    else       t_d <= t_d + 1;
  end

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) t_s <= 0;
    else       t_s <= t_s + 1;
  end

  hv_sync_generator_if vid_d ();
  hv_sync_generator_if vid_s ();

  hv_sync_generator dut (
    .clk   (clk),
    .reset (rst_d),
    .vid   (vid_d.master)
  );

  hv_sync_generator #(
    .H_DISPLAY (SHD), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_DISPLAY (SVD), .V_BOTTOM (SVF), .V_SYNC (SVS), .V_TOP (SVB)
  ) dut_s (
    .clk   (clk),
    .reset (rst_s),
    .vid   (vid_s.master)
  );

  // ---------------- reference model ----------------
  function automatic pix_t model(input int t, input int hd, input int hf, input int hs,
                                 input int hb, input int vd, input int vf, input int vs,
                                 input int vb);
    int   htot;
    int   vtot;
    int   h;
    int   v;
    pix_t m;
    htot = hd + hf + hs + hb;
    vtot = vd + vf + vs + vb;
    h    = t % htot;
    v    = (t / htot) % vtot;
    m.h  = h[9:0];
    m.v  = v[9:0];
    m.hs = (h >= hd + hf && h < hd + hf + hs) ? SYNC_ON : ~SYNC_ON;
    m.vs = (v >= vd + vf && v < vd + vf + vs) ? SYNC_ON : ~SYNC_ON;
    m.de = (h < hd) && (v < vd);
    m.fe = (h == htot - 1) && (v == vtot - 1);
    return m;
  endfunction

  function automatic pix_t model_d(input int t);
    return model(t, H_DISPLAY, H_FRONT, H_SYNC, H_BACK, V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
  endfunction

  function automatic pix_t model_s(input int t);
    return model(t, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB);
  endfunction

  function automatic pix_t act_d();
    return {vid_d.hpos, vid_d.vpos, vid_d.hsync, vid_d.vsync, vid_d.display_on, vid_d.frame_end};
  endfunction

  function automatic pix_t act_s();
    return {vid_s.hpos, vid_s.vpos, vid_s.hsync, vid_s.vsync, vid_s.display_on, vid_s.frame_end};
  endfunction

  function automatic string fmt(input pix_t p);
    return $sformatf("(h=%0d v=%0d hs=%b vs=%b de=%b fe=%b)", p.h, p.v, p.hs, p.vs, p.de, p.fe);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    pix_t got;
    repeat ($urandom_range(50, 400)) @(posedge clk);
    #7 rst_d = 1'b1;
    #1;
    got = act_d();
    n_cmp++;
    if (got !== RST_PIX) begin
      n_err++;
      $display("FAIL reset_async got %s exp %s", fmt(got), fmt(RST_PIX));
    end
    @(negedge clk);
    rst_d = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vid_d.hpos !== 10'd1 || vid_d.vpos !== 10'd0) begin
      n_err++;
      $display("FAIL reset_release got h=%0d v=%0d exp h=1 v=0", vid_d.hpos, vid_d.vpos);
    end
  endtask

  task automatic test_horizontal();
    pix_t got;
    pix_t exp;
    int   low_cnt = 0;
    bit   counting = 1'b0;
    for (int i = 0; i < 3 * 800; i++) begin
      @(negedge clk);
      exp = model_d(t_d);
      got = act_d();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL h_scan t=%0d got %s exp %s", t_d, fmt(got), fmt(exp));
      end
      if (exp.h == 10'd0) begin
        low_cnt  = 0;
        counting = 1'b1;
      end
      if (got.hs == SYNC_ON) low_cnt++;
      if (exp.h inside {10'd655, 10'd752}) begin
        n_cmp++;
        if (got.hs !== ~SYNC_ON) begin
          n_err++;
          $display("FAIL hsync_outside h=%0d got %b exp %b", exp.h, got.hs, ~SYNC_ON);
        end
      end
      if (exp.h inside {10'd656, 10'd751}) begin
        n_cmp++;
        if (got.hs !== SYNC_ON) begin
          n_err++;
          $display("FAIL hsync_inside h=%0d got %b exp %b", exp.h, got.hs, SYNC_ON);
        end
      end
      if (exp.v == 10'd0 && exp.h inside {10'd639, 10'd640}) begin
        n_cmp++;
        if (got.de !== (exp.h == 10'd639)) begin
          n_err++;
          $display("FAIL de_h_edge h=%0d got %b exp %b", exp.h, got.de, exp.h == 10'd639);
        end
      end
      if (counting && exp.h == 10'd799) begin
        n_cmp++;
        if (low_cnt !== 96) begin
          n_err++;
          $display("FAIL hsync_width got %0d exp 96", low_cnt);
        end
      end
    end
  endtask

  task automatic test_line_wrap();
    pix_t       exp;
    logic [9:0] v_before;
    bit         done = 1'b0;
    for (int i = 0; i < 801 && !done; i++) begin
      @(negedge clk);
      exp = model_d(t_d);
      if (exp.h == 10'd799) begin
        v_before = exp.v;
        n_cmp++;
        if (vid_d.hpos !== 10'd799 || vid_d.vpos !== v_before) begin
          n_err++;
          $display("FAIL line_end got h=%0d v=%0d exp h=799 v=%0d", vid_d.hpos, vid_d.vpos, v_before);
        end
        @(negedge clk);
        n_cmp++;
        if (vid_d.hpos !== 10'd0 || vid_d.vpos !== v_before + 10'd1) begin
          n_err++;
          $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=%0d", vid_d.hpos, vid_d.vpos, v_before + 10'd1);
        end
        done = 1'b1;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL line_wrap_timeout got no h=799 within 801 clocks exp one");
    end
  endtask

  task automatic test_random_reset();
    pix_t got;
    pix_t exp;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(200, 1500)) begin
        @(negedge clk);
        exp = model_d(t_d);
        got = act_d();
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL rand_run t=%0d got %s exp %s", t_d, fmt(got), fmt(exp));
        end
      end
      @(posedge clk);
      #($urandom_range(2, 37));
      rst_d = 1'b1;
      #1;
      got = act_d();
      n_cmp++;
      if (got !== RST_PIX) begin
        n_err++;
        $display("FAIL rand_rst got %s exp %s", fmt(got), fmt(RST_PIX));
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_d = 1'b0;
    end
  endtask

  task automatic test_frame();
    pix_t got;
    pix_t exp;
    int   act_cnt = 0;
    int   vs_cnt  = 0;
    int   since   = -1;
    bit   at_last = 1'b0;
    rst_s = 1'b1;
    #1;
    got = act_s();
    n_cmp++;
    if (got !== RST_PIX) begin
      n_err++;
      $display("FAIL s_reset got %s exp %s", fmt(got), fmt(RST_PIX));
    end
    @(negedge clk);
    rst_s = 1'b0;
    for (int i = 0; i < 3 * S_FRAME + int'($urandom_range(0, 100)); i++) begin
      @(negedge clk);
      exp = model_s(t_s);
      got = act_s();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL frame_scan t=%0d got %s exp %s", t_s, fmt(got), fmt(exp));
      end
      if (at_last) begin
        n_cmp++;
        if (got.h !== 10'd0 || got.v !== 10'd0) begin
          n_err++;
          $display("FAIL frame_wrap got h=%0d v=%0d exp h=0 v=0", got.h, got.v);
        end
      end
      at_last = (exp.h == 10'd24 && exp.v == 10'd18);
      if (exp.h inside {10'd0, 10'd24} && exp.v inside {10'd13, 10'd14, 10'd15, 10'd16}) begin
        n_cmp++;
        if (got.vs !== ((exp.v inside {10'd14, 10'd15}) ? SYNC_ON : ~SYNC_ON)) begin
          n_err++;
          $display("FAIL vsync_line v=%0d h=%0d got %b", exp.v, exp.h, got.vs);
        end
      end
      if ((exp.h == 10'd15 && exp.v == 10'd11) || (exp.h == 10'd16 && exp.v == 10'd0) ||
          (exp.h == 10'd0 && exp.v == 10'd12)) begin
        n_cmp++;
        if (got.de !== (exp.h == 10'd15)) begin
          n_err++;
          $display("FAIL de_edge h=%0d v=%0d got %b exp %b", exp.h, exp.v, got.de, exp.h == 10'd15);
        end
      end
      if (t_s >= S_FRAME && t_s < 2 * S_FRAME) begin
        if (got.de) act_cnt++;
        if (got.vs == SYNC_ON) vs_cnt++;
      end
      if (t_s == 2 * S_FRAME) begin
        n_cmp++;
        if (act_cnt !== SHD * SVD || vs_cnt !== SVS * (SHD + SHF + SHS + SHB)) begin
          n_err++;
          $display("FAIL frame_counts got active=%0d vsync=%0d exp active=%0d vsync=%0d",
                   act_cnt, vs_cnt, SHD * SVD, SVS * (SHD + SHF + SHS + SHB));
        end
      end
      if (since >= 0) since++;
      if (got.h == 10'd0 && got.v == 10'd0) begin
        if (since >= 0) begin
          n_cmp++;
          if (since !== S_FRAME) begin
            n_err++;
            $display("FAIL frame_len got %0d exp %0d", since, S_FRAME);
          end
        end
        since = 0;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_d = 1'b0;
    test_reset();
    test_horizontal();
    test_line_wrap();
    test_random_reset();
    test_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hv_sync_generator.md
# hv_sync_generator

Free-running 640x480 @ 60 Hz VGA timing generator (800x525 total, 25.175 MHz pixel clock, one pixel per clock). It produces horizontal/vertical sync, a display-active flag and the current pixel coordinates. It sits at the front of the video pipeline. Downstream pixel logic (cellular-automaton renderer, colour mux) derives every pixel from `hpos`/`vpos`/`display_on` in the same cycle.

## Interface
Parameters:
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_DISPLAY`, 480, visible lines per frame
- `V_BOTTOM`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_TOP`, 33, vertical back porch (lines)

Ports:
- `clk` in 1: pixel clock; all state on rising edge
- `reset` in 1: asynchronous, active-high reset
- `hsync` out 1: horizontal sync, active-low by default
- `vsync` out 1: vertical sync, active-low by default
- `display_on` out 1: high while (`hpos`,`vpos`) is inside the visible area
- `hpos` out 10: current column, 0..799
- `vpos` out 10: current line, 0..524

## Operation
- Derived constants:
  - H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 = 799
  - H_SYNC_START = H_DISPLAY+H_FRONT = 656
  - H_SYNC_END = H_SYNC_START+H_SYNC-1 = 751
  - V_MAX = 524
  - V_SYNC_START = 490
  - V_SYNC_END = 491
- Horizontal counter `hpos`:
  - increments by 1 every clock
  - at H_MAX it wraps to 0 and the line ends
- Vertical counter `vpos`:
  - increments only on the clock where `hpos` wraps
  - at V_MAX with line end, it wraps to 0 (frame end)
- `hsync` is asserted (low) exactly while H_SYNC_START <= `hpos` <= H_SYNC_END; otherwise high.
- `vsync` is asserted (low) exactly while V_SYNC_START <= `vpos` <= V_SYNC_END, for the whole line including blanking; otherwise high.
- `display_on` = (`hpos` < H_DISPLAY) && (`vpos` < V_DISPLAY).
- Counters are unsigned 10-bit and never take values above H_MAX / V_MAX.
- No enable input: the generator runs continuously out of reset.

## Timing
- Reset (asynchronous assert, synchronous-edge release): `hpos`=0, `vpos`=0, `hsync`=1, `vsync`=1, `display_on`=1.
- First clock after reset release: `hpos`=1.
- `hsync` and `vsync` are registered, but computed from the next counter values. They are therefore cycle-aligned with `hpos`/`vpos`, with zero latency relative to the coordinates.
- `display_on` is a combinational decode of the registered counters, with the same cycle alignment.
- Line = 800 clocks; frame = 420 000 clocks.
- hsync low for 96 clocks per line; vsync low for 1600 clocks per frame.
- Reset asserted mid-frame: all outputs return to reset values immediately, without waiting for a clock. Counting restarts from (0,0).

## Configuration
- Macro `HVSYNC_POS_POLARITY_EN`:
  - when defined, `hsync` and `vsync` are active-high: high inside the sync windows, low elsewhere, and reset value 0
  - when undefined (default, VGA 640x480 standard), both are active-low as described above
- Counters and `display_on` are unaffected by the macro.

## Structure
- Shared package `hvsync_pkg` holds:
  - the default timing constants (the eight porch/width values)
  - derived MAX/SYNC_START/SYNC_END localparams
  - the 10-bit coordinate typedef `coord_t`
- One natural sub-module, `sync_axis_counter`, instantiated twice (horizontal, vertical). It is parameterised by display/front/sync/back and has:
  - an advance input
  - count, wrap and sync-window outputs
- Horizontal advance = 1; vertical advance = horizontal wrap.

## Test plan
- Reset: assert `reset` mid-frame without a clock edge → `hpos`=0, `vpos`=0, `hsync`=1, `vsync`=1, `display_on`=1 immediately; release → `hpos`=1 after the first clock.
- Horizontal window:
  - `hsync`=1 at `hpos`=655, 0 at 656 and at 751, 1 at 752
  - exactly 96 low clocks per line
- Line wrap: `hpos` 799 → 0 with `vpos` N → N+1 on the same edge; `vpos` constant across `hpos` 0..799.
- Vertical window and frame wrap:
  - `vsync`=0 for all of lines 490 and 491, 1 on lines 489 and 492
  - (`hpos`,`vpos`)=(799,524) → (0,0) on the next clock
  - frame length is exactly 420 000 clocks
- `display_on` boundaries:
  - 1 at (639,479); 0 at (640,0) and at (0,480)
  - exactly 307 200 active clocks per frame
- With `HVSYNC_POS_POLARITY_EN` defined: same windows with inverted levels (`hsync`=1 only for `hpos` 656..751), and reset value of sync outputs 0.
